// File: rtl/cas_seq_sorter_if.sv
// Load/drain handshake bundle for the sequential descending sorter.
// master drives words in and takes sorted words out; slave is the sorter.
interface cas_seq_sorter_if #(
   parameter int W = 10
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/cas_seq_sorter.sv
// Block sorter: serial load, odd-even transposition sort, descending drain.
// Built around the 2-input compare-and-swap rule (swap on subtract borrow).
module cas_seq_sorter #(
   parameter int SNG_WIDTH = 10,
   parameter int NUM_ELEMS = 8,
   parameter int CNT_W     = $clog2(NUM_ELEMS) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   cas_seq_sorter_if.slave   bus,
   output logic              busy
);
   localparam int IW = $clog2(NUM_ELEMS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEMS - 1);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     load_cnt, load_d;
   logic [CNT_W-1:0]     sort_cnt, sort_d;
   logic [CNT_W-1:0]     drain_idx, drain_d;
   logic                 load_we;
   logic [SNG_WIDTH-1:0] mem [NUM_ELEMS];
   logic [SNG_WIDTH-1:0] srt [NUM_ELEMS];
   logic [NUM_ELEMS-2:0] swap;

   function automatic logic cas_borrow(
      input logic [SNG_WIDTH-1:0] a,
      input logic [SNG_WIDTH-1:0] b
   );
      logic [SNG_WIDTH:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[SNG_WIDTH];
   endfunction

   // pair (g,g+1) is active when its parity matches the phase
   for (genvar g = 0; g < NUM_ELEMS - 1; g++) begin : g_cas
      assign swap[g] = (state_q == SORT)
                    && (sort_cnt[0] == 1'(g % 2))
                    && cas_borrow(mem[g], mem[g+1]);
   end

   always_comb begin
      for (int i = 0; i < NUM_ELEMS; i++) srt[i] = mem[i];
      for (int i = 0; i < NUM_ELEMS - 1; i++) begin
         if (swap[i]) begin
            srt[i]   = mem[i+1];
            srt[i+1] = mem[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         load_cnt  <= '0;
         sort_cnt  <= '0;
         drain_idx <= '0;
      end else begin
         state_q   <= state_d;
         load_cnt  <= load_d;
         sort_cnt  <= sort_d;
         drain_idx <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load_d  = load_cnt;
      sort_d  = sort_cnt;
      drain_d = drain_idx;
      load_we = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (bus.in_valid) begin
               load_we = 1'b1;
               if (load_cnt == LAST) begin
                  load_d  = '0;
                  sort_d  = '0;
                  state_d = SORT;
               end else begin
                  load_d = load_cnt + 1'b1;
               end
            end
         end
         SORT: begin
            if (sort_cnt == LAST) begin
               sort_d  = '0;
               drain_d = '0;
               state_d = DRAIN;
            end else begin
               sort_d = sort_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (drain_idx == LAST) begin
                  drain_d = '0;
                  state_d = LOAD;
               end else begin
                  drain_d = drain_idx + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // storage is deliberately not reset; a block is always fully reloaded
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem[load_cnt[IW-1:0]] <= bus.in_data;
      end else if (state_q == SORT) begin
         for (int i = 0; i < NUM_ELEMS; i++) mem[i] <= srt[i];
      end
   end

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_last  = (state_q == DRAIN) && (drain_idx == LAST);
   assign bus.out_data  = (state_q == DRAIN) ? mem[drain_idx[IW-1:0]] : '0;
   assign busy          = (state_q != LOAD);
endmodule

// File: tb/tb_cas_seq_sorter.sv
// Directed bench for cas_seq_sorter: load, sort latency, drain order,
// stalls, resets mid-block and back-to-back blocks.
module tb_cas_seq_sorter;
   localparam int W = 10;
   localparam int N = 8;
   typedef logic [W-1:0] blk_t [N];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   cas_seq_sorter_if #(.W(W)) bus ();

   cas_seq_sorter #(
      .SNG_WIDTH(W),
      .NUM_ELEMS(N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_blk(input blk_t d, input bit gaps);
      int  i = 0;
      int  n = 0;
      bit  fire;
      while (i < N && n < 300) begin
         bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_data  = d[i];
         fire = bus.in_valid && bus.in_ready;
         step();
         n++;
         if (fire) i++;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      total++;
      if (i != N) begin
         bad++;
         $display("FAIL load_count got=%0d want=%0d", i, N);
      end
   endtask

   task automatic wait_out(input bit noswap);
      int n = 0;
      bit swp = 0;
      while (!bus.out_valid && n < 100) begin
         if (|dut.swap) swp = 1;
         step();
         n++;
      end
      total++;
      if (!bus.out_valid) begin
         bad++;
         $display("FAIL out_valid_timeout got=0 want=1");
      end
      total++;
      if (n != N) begin
         bad++;
         $display("FAIL sort_latency got=%0d want=%0d", n, N);
      end
      if (noswap) begin
         total++;
         if (swp) begin
            bad++;
            $display("FAIL no_swap got=1 want=0");
         end
      end
   endtask

   task automatic drain(input blk_t e, input int cnt, input bit tog);
      int i = 0;
      int n = 0;
      bit fire;
      while (i < cnt && n < 300) begin
         bus.out_ready = tog ? 1'($urandom_range(0, 1)) : 1'b1;
         total++;
         if (bus.in_ready && bus.out_valid) begin
            bad++;
            $display("FAIL ready_valid_overlap at idx=%0d", i);
         end
         total++;
         if (!bus.out_valid) begin
            bad++;
            $display("FAIL drain_valid idx=%0d got=0 want=1", i);
         end else if (bus.out_data !== e[i] ||
                      bus.out_last !== (i == N - 1)) begin
            bad++;
            $display("FAIL drain_word idx=%0d got=%0d/%0b want=%0d/%0b",
                     i, bus.out_data, bus.out_last, e[i], (i == N - 1));
         end
         fire = bus.out_valid && bus.out_ready;
         step();
         n++;
         if (fire) i++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      total++;
      if (i != cnt) begin
         bad++;
         $display("FAIL drain_count got=%0d want=%0d", i, cnt);
      end
      if (cnt == N) begin
         total++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
             busy !== 1'b0) begin
            bad++;
            $display("FAIL post_block got=v%0b r%0b b%0b want=v0 r1 b0",
                     bus.out_valid, bus.in_ready, busy);
         end
      end
   endtask

   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          busy !== 1'b0 || bus.out_last !== 1'b0) begin
         bad++;
         $display("FAIL %s got=v%0b r%0b b%0b l%0b want=v0 r1 b0 l0",
                  tag, bus.out_valid, bus.in_ready, busy, bus.out_last);
      end
      #1;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_last !== 1'b0 || busy !== 1'b0 ||
          bus.out_data !== '0) begin
         bad++;
         $display("FAIL reset_state got=r%0b v%0b l%0b b%0b d%0d",
                  bus.in_ready, bus.out_valid, bus.out_last, busy,
                  bus.out_data);
      end
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      blk_t d = '{10'd3, 10'd9, 10'd0, 10'd1023, 10'd5, 10'd5, 10'd512, 10'd7};
      blk_t e = '{10'd1023, 10'd512, 10'd9, 10'd7, 10'd5, 10'd5, 10'd3, 10'd0};
      load_blk(d, 1'b0);
      wait_out(1'b0);
      drain(e, N, 1'b0);
   endtask

   task automatic test_sorted();
      blk_t d = '{10'd800, 10'd700, 10'd600, 10'd500,
                  10'd400, 10'd300, 10'd200, 10'd100};
      load_blk(d, 1'b0);
      wait_out(1'b1);
      drain(d, N, 1'b0);
   endtask

   task automatic test_stall();
      blk_t d = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
      blk_t e = '{10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0};
      load_blk(d, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 10'd999;
      wait_out(1'b0);
      drain(e, N, 1'b1);
   endtask

   task automatic test_edges();
      blk_t q = '{default: 10'd341};
      blk_t d = '{10'd0, 10'd1023, 10'd0, 10'd1023,
                  10'd0, 10'd1023, 10'd0, 10'd1023};
      blk_t e = '{10'd1023, 10'd1023, 10'd1023, 10'd1023,
                  10'd0, 10'd0, 10'd0, 10'd0};
      load_blk(q, 1'b0);
      wait_out(1'b1);
      drain(q, N, 1'b0);
      load_blk(d, 1'b0);
      wait_out(1'b0);
      drain(e, N, 1'b0);
   endtask

   task automatic test_midreset();
      blk_t d = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8};
      blk_t e = '{10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 10'(100 + i);
         step();
      end
      bus.in_valid = 1'b0;
      pulse_reset("reset_mid_load");
      load_blk(d, 1'b0);
      wait_out(1'b0);
      drain(e, 3, 1'b0);
      pulse_reset("reset_mid_drain");
      load_blk(d, 1'b0);
      wait_out(1'b0);
      drain(e, N, 1'b0);
   endtask

   task automatic test_back_to_back();
      blk_t a = '{10'd50, 10'd60, 10'd40, 10'd70, 10'd30, 10'd80, 10'd20, 10'd10};
      blk_t b = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60, 10'd70, 10'd80};
      blk_t e = '{10'd80, 10'd70, 10'd60, 10'd50, 10'd40, 10'd30, 10'd20, 10'd10};
      load_blk(a, 1'b0);
      wait_out(1'b0);
      drain(e, N, 1'b0);
      load_blk(b, 1'b0);
      wait_out(1'b0);
      drain(e, N, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sorted();
      test_stall();
      test_edges();
      test_midreset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
